// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the 19-bit CPU control path: opcodes, ALU codes, FSM states and
// instruction field positions.
package cpu_control_unit_pkg;

   localparam int DATA_W  = 19;
   localparam int REG_W   = 3;
   localparam int IMM_W   = 9;
   localparam int OP_MSB  = 18;
   localparam int OP_LSB  = 15;
   localparam int RD_LSB  = 12;
   localparam int RS1_LSB = 9;
   localparam int RS2_LSB = 6;

   localparam logic [3:0] OP_LDI  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b0111;
   localparam logic [3:0] OP_JZ   = 4'b1000;
   localparam logic [3:0] OP_NOP  = 4'b1001;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOT = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CL_ALU, CL_LDI, CL_JMP, CL_JZ, CL_NOP, CL_HALT, CL_ILL
   } iclass_e;

   typedef struct packed {
      iclass_e          cls;
      logic [2:0]       alu_op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [IMM_W-1:0] imm;
      logic             illegal;
   } dec_t;

   // Opcodes 0000..0101 map directly onto the ALU operation codes.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= 4'b0101;
   endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-memory, ALU and register-file control bundle between sequencer and datapath.
interface cpu_control_unit_if
   import cpu_control_unit_pkg::*;
#(
   parameter int PC_W = 8
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic [2:0]        alu_op;
   logic              alu_zero;
   logic [REG_W-1:0]  rf_raddr_a;
   logic [REG_W-1:0]  rf_raddr_b;
   logic [REG_W-1:0]  rf_waddr;
   logic              rf_we;
   logic              rf_wsel;
   logic [DATA_W-1:0] imm_out;

   modport master (
      output imem_req, imem_addr, alu_op, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel,
             imm_out,
      input  imem_ack, imem_rdata, alu_zero
   );

   modport slave (
      input  imem_req, imem_addr, alu_op, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel,
             imm_out,
      output imem_ack, imem_rdata, alu_zero
   );
endinterface

// File: rtl/cpu_control_unit_decode.sv
// Combinational instruction decoder: splits the IR into fields and classifies the opcode.
module cpu_control_unit_decode
   import cpu_control_unit_pkg::*;
(
   input  logic [DATA_W-1:0] ir_i,
   output dec_t              dec_o
);

   logic [3:0] op;
   assign op = ir_i[OP_MSB:OP_LSB];

   always_comb begin
      dec_o         = '0;
      dec_o.cls     = CL_NOP;
      dec_o.alu_op  = ALU_ADD;
      dec_o.rd      = ir_i[RD_LSB +: REG_W];
      dec_o.rs1     = ir_i[RS1_LSB +: REG_W];
      dec_o.rs2     = ir_i[RS2_LSB +: REG_W];
      dec_o.imm     = ir_i[IMM_W-1:0];
      dec_o.illegal = 1'b0;
      if (is_alu_op(op)) begin
         dec_o.cls    = CL_ALU;
         dec_o.alu_op = op[2:0];
      end else begin
         case (op)
            OP_LDI:  dec_o.cls = CL_LDI;
            OP_JMP:  dec_o.cls = CL_JMP;
            OP_JZ:   dec_o.cls = CL_JZ;
            OP_NOP:  dec_o.cls = CL_NOP;
            OP_HALT: dec_o.cls = CL_HALT;
            default: begin
               dec_o.cls     = CL_ILL;
               dec_o.illegal = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer: fetches over imem req/ack, decodes, drives the ALU and register file.
module cpu_control_unit
   import cpu_control_unit_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   cpu_control_unit_if.master bus,
   output logic               busy_o,
   output logic               halted_o,
   output logic               illegal_o
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              z_q, z_d;
   logic              ill_q, ill_d;

   dec_t              dec;
   logic [PC_W-1:0]   target;
   logic              req, we, wsel;
   logic [2:0]        aop;
   logic [REG_W-1:0]  ra, rb, wa;
   logic [DATA_W-1:0] imm;

   cpu_control_unit_decode u_decode (
      .ir_i  (ir_q),
      .dec_o (dec)
   );

   assign target = ir_q[PC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         z_q     <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      z_d     = z_q;
      ill_d   = ill_q;
      req     = 1'b0;
      we      = 1'b0;
      wsel    = 1'b0;
      aop     = ALU_ADD;
      ra      = '0;
      rb      = '0;
      wa      = '0;
      imm     = '0;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start_i) begin
               state_d = ST_FETCH;
               pc_d    = RESET_PC;
               ill_d   = 1'b0;
            end
         end
         ST_FETCH: begin
            req = 1'b1;
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            pc_d = pc_q + PC_W'(1);
            if (dec.illegal) begin
               ill_d   = 1'b1;
               state_d = ST_HALT;
            end else if (dec.cls == CL_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (dec.cls)
               CL_ALU: begin
                  aop     = dec.alu_op;
                  ra      = dec.rs1;
                  rb      = dec.rs2;
                  z_d     = bus.alu_zero;
                  state_d = ST_WB;
               end
               CL_LDI: begin
                  imm     = DATA_W'(dec.imm);
                  state_d = ST_WB;
               end
               CL_JMP:  pc_d = target;
               CL_JZ:   if (z_q) pc_d = target;
               default: ;
            endcase
         end
         ST_WB: begin
            // ALU operands stay on the bus so the result is still valid at the write.
            we      = 1'b1;
            wa      = dec.rd;
            wsel    = (dec.cls == CL_LDI);
            state_d = ST_FETCH;
            if (dec.cls == CL_ALU) begin
               aop = dec.alu_op;
               ra  = dec.rs1;
               rb  = dec.rs2;
            end else begin
               imm = DATA_W'(dec.imm);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.imem_req   = req;
   assign bus.imem_addr  = pc_q;
   assign bus.alu_op     = aop;
   assign bus.rf_raddr_a = ra;
   assign bus.rf_raddr_b = rb;
   assign bus.rf_waddr   = wa;
   assign bus.rf_we      = we;
   assign bus.rf_wsel    = wsel;
   assign bus.imm_out    = imm;

   assign busy_o    = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_WB);
   assign halted_o  = (state_q == ST_HALT);
   assign illegal_o = ill_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level reference model plus directed literal checks.
module tb_cpu_control_unit;
   import cpu_control_unit_pkg::*;

   localparam int PC_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, halted, illegal;

   cpu_control_unit_if #(.PC_W(PC_W)) bus ();

   cpu_control_unit #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start),
      .bus       (bus.master),
      .busy_o    (busy),
      .halted_o  (halted),
      .illegal_o (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [7:0]  addr;
      logic [2:0]  aop, ra, rb, wa;
      logic        we, wsel;
      logic [18:0] imm;
      logic        busy, halted, ill, set_z;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   int          cycle_cnt = 0;
   logic [18:0] mem [256];

   // Reference model: per-instruction schedule of expected output cycles
   exp_t        sched[$];
   int          m_mode;
   logic [7:0]  m_pc, m_next;
   logic        m_z, m_ill, m_end_halt, m_end_ill;

   bit          dir_mode, hold_ack;
   int          wait_cnt, rnd_delay;
   logic [7:0]  fetch_log[$];
   int          first_req_cyc, first_we_cyc, first_aop, we_count;
   logic [2:0]  we_wa;
   logic        we_wsel;
   logic [18:0] we_imm;
   logic [7:0]  exp_fa [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'hFF, 8'h00};

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, want, cycle_cnt);
      end
   endtask

   function automatic exp_t blank();
      exp_t e;
      e = '{default: '0};
      return e;
   endfunction

   task automatic model_reset();
      sched.delete();
      m_mode = 0; m_pc = 8'h00; m_next = 8'h00;
      m_z = 1'b0; m_ill = 1'b0; m_end_halt = 1'b0; m_end_ill = 1'b0;
   endtask

   task automatic build(input logic [18:0] ins);
      exp_t d, e, w;
      logic [3:0] op;
      logic [7:0] np;
      op = ins[18:15];
      np = m_pc + 8'd1;
      d = blank(); d.busy = 1'b1; d.addr = m_pc;
      sched.push_back(d);
      m_end_halt = 1'b0; m_end_ill = 1'b0; m_next = np;
      e = blank(); e.busy = 1'b1; e.addr = np;
      if (op <= 4'd5) begin
         e.aop = op[2:0]; e.ra = ins[11:9]; e.rb = ins[8:6]; e.set_z = 1'b1;
         w = e; w.set_z = 1'b0; w.wa = ins[14:12]; w.we = 1'b1;
         sched.push_back(e); sched.push_back(w);
      end else if (op == 4'd6) begin
         e.imm = {10'd0, ins[8:0]};
         w = e; w.wa = ins[14:12]; w.we = 1'b1; w.wsel = 1'b1;
         sched.push_back(e); sched.push_back(w);
      end else if (op == 4'd7) begin
         m_next = ins[7:0];
         sched.push_back(e);
      end else if (op == 4'd8) begin
         if (m_z) m_next = ins[7:0];
         sched.push_back(e);
      end else if (op == 4'd9) begin
         sched.push_back(e);
      end else if (op == 4'd15) begin
         m_end_halt = 1'b1;
      end else begin
         m_end_halt = 1'b1; m_end_ill = 1'b1;
      end
   endtask

   task automatic model_step(input logic rst_v, start_v, ack_v, zero_v, input logic [18:0] rdata_v);
      exp_t e;
      if (!rst_v) begin
         model_reset();
      end else if (sched.size() > 0) begin
         e = sched.pop_front();
         if (e.set_z) m_z = zero_v;
         if (sched.size() == 0) begin
            m_pc   = m_next;
            m_mode = m_end_halt ? 2 : 1;
            if (m_end_ill) m_ill = 1'b1;
         end
      end else if (m_mode == 1) begin
         if (ack_v) build(rdata_v);
      end else if (start_v) begin
         m_pc = 8'h00; m_ill = 1'b0; m_mode = 1;
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      if (sched.size() > 0) begin
         e = sched[0];
      end else begin
         e = blank();
         e.addr   = m_pc;
         e.req    = (m_mode == 1);
         e.busy   = (m_mode == 1);
         e.halted = (m_mode == 2);
      end
      e.ill = m_ill;
      cmp("imem_req",   bus.imem_req,   e.req);
      cmp("imem_addr",  bus.imem_addr,  e.addr);
      cmp("alu_op",     bus.alu_op,     e.aop);
      cmp("rf_raddr_a", bus.rf_raddr_a, e.ra);
      cmp("rf_raddr_b", bus.rf_raddr_b, e.rb);
      cmp("rf_waddr",   bus.rf_waddr,   e.wa);
      cmp("rf_we",      bus.rf_we,      e.we);
      cmp("rf_wsel",    bus.rf_wsel,    e.wsel);
      cmp("imm_out",    bus.imm_out,    e.imm);
      cmp("busy",       busy,           e.busy);
      cmp("halted",     halted,         e.halted);
      cmp("illegal",    illegal,        e.ill);
   endtask

   function automatic int want_delay();
      if (dir_mode) return (bus.imem_addr == 8'hFF) ? 3 : 0;
      return rnd_delay;
   endfunction

   task automatic tick(input logic start_v, input logic rst_v);
      logic ack_v, zero_v;
      logic [18:0] rd_v;
      @(negedge clk);
      cycle_cnt++;
      check_outputs();
      if (bus.imem_req && first_req_cyc < 0) first_req_cyc = cycle_cnt;
      if (bus.alu_op != 3'b000 && first_aop < 0) first_aop = int'(bus.alu_op);
      if (bus.rf_we) begin
         we_count++;
         if (first_we_cyc < 0) begin
            first_we_cyc = cycle_cnt;
            we_wa = bus.rf_waddr; we_wsel = bus.rf_wsel; we_imm = bus.imm_out;
         end
      end
      ack_v = 1'b0;
      rd_v  = 19'($urandom);
      if (!rst_v) begin
         wait_cnt = 0;
      end else if (bus.imem_req) begin
         if (!hold_ack && wait_cnt >= want_delay()) begin
            ack_v = 1'b1;
            rd_v  = mem[bus.imem_addr];
            wait_cnt = 0;
            rnd_delay = int'($urandom_range(0, 3));
            fetch_log.push_back(bus.imem_addr);
         end else begin
            wait_cnt++;
         end
      end else if (!dir_mode && $urandom_range(0, 7) == 0) begin
         ack_v = 1'b1;
      end
      if (dir_mode) zero_v = (bus.alu_op == 3'b001) && (bus.rf_raddr_a == bus.rf_raddr_b);
      else          zero_v = 1'($urandom_range(0, 1));
      rst_n = rst_v; start = start_v;
      bus.imem_ack = ack_v; bus.imem_rdata = rd_v; bus.alu_zero = zero_v;
      model_step(rst_v, start_v, ack_v, zero_v, rd_v);
   endtask

   task automatic clear_logs();
      fetch_log.delete();
      first_req_cyc = -1; first_we_cyc = -1; first_aop = -1; we_count = 0;
   endtask

   function automatic logic [18:0] rand_instr();
      logic [18:0] w;
      int unsigned r;
      r = $urandom_range(0, 19);
      w = 19'($urandom);
      if (r < 10)       w[18:15] = 4'($urandom_range(0, 5));
      else if (r < 12)  w[18:15] = 4'b0110;
      else if (r < 14)  w[18:15] = 4'b0111;
      else if (r < 16)  w[18:15] = 4'b1000;
      else if (r == 16) w[18:15] = 4'b1001;
      else if (r == 17) w[18:15] = 4'b1111;
      else if (r == 18) w[18:15] = 4'($urandom_range(10, 14));
      return w;
   endfunction

   initial begin
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.alu_zero = 1'b0;
      model_reset();
      dir_mode = 1'b1; hold_ack = 1'b0; wait_cnt = 0; rnd_delay = 0;
      clear_logs();
      for (int i = 0; i < 256; i++) mem[i] = {4'b1001, 15'd0};

      // Reset asserted while a fetch is outstanding
      tick(1'b0, 1'b0);
      hold_ack = 1'b1;
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      #1;
      cmp("rst_imem_req", bus.imem_req, 0);
      cmp("rst_imem_addr", bus.imem_addr, 0);
      cmp("rst_busy", busy, 0);
      cmp("rst_rf_we", bus.rf_we, 0);
      cmp("rst_alu_op", bus.alu_op, 0);
      hold_ack = 1'b0;
      tick(1'b0, 1'b1);

      // LDI, SUB/JZ taken, ADD/LDI/JZ not taken, JMP to 0xFF, NOP wrap with slow ack
      mem[8'h00] = {4'b0110, 3'd1, 3'd0, 9'h1FF};
      mem[8'h01] = {4'b0001, 3'd2, 3'd1, 3'd1, 6'd0};
      mem[8'h02] = {4'b1000, 7'd0, 8'h10};
      mem[8'h10] = {4'b0000, 3'd3, 3'd1, 3'd2, 6'd0};
      mem[8'h11] = {4'b0110, 3'd4, 3'd0, 9'h005};
      mem[8'h12] = {4'b1000, 7'd0, 8'h20};
      mem[8'h13] = {4'b0111, 7'd0, 8'hFF};
      mem[8'hFF] = {4'b1001, 15'd0};
      clear_logs();
      tick(1'b1, 1'b1);
      for (int n = 0; n < 200 && fetch_log.size() < 9; n++) tick(1'b0, 1'b1);
      cmp("fetch_count", fetch_log.size(), 9);
      for (int i = 0; i < 9 && i < fetch_log.size(); i++) cmp("fetch_addr_seq", fetch_log[i], exp_fa[i]);
      cmp("ldi_we_cycle", first_we_cyc - first_req_cyc + 1, 4);
      cmp("ldi_waddr", we_wa, 1);
      cmp("ldi_wsel", we_wsel, 1);
      cmp("ldi_imm", we_imm, 19'h001FF);
      cmp("sub_alu_op", first_aop, 1);

      // Undefined opcode halts with sticky illegal; start clears it
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      mem[8'h00] = {4'b1010, 15'd0};
      clear_logs();
      tick(1'b1, 1'b1);
      for (int n = 0; n < 20 && !halted; n++) tick(1'b0, 1'b1);
      cmp("ill_illegal", illegal, 1);
      cmp("ill_halted", halted, 1);
      cmp("ill_no_write", we_count, 0);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      cmp("restart_illegal", illegal, 0);
      cmp("restart_req", bus.imem_req, 1);
      cmp("restart_addr", bus.imem_addr, 0);

      // Randomized programs, handshake delays, start pulses and occasional resets
      dir_mode = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = rand_instr();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      for (int n = 0; n < 4000; n++)
         tick($urandom_range(0, 5) == 0, $urandom_range(0, 599) != 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
